// File: rtl/fabric_pkg.sv
// Shared types for the redundant request fabric: dual-copy packet layout,
// failover select bundle and monitor FSM states.
package fabric_pkg;

  localparam int RFAB_NCLS      = 4;
  localparam int RFAB_NSLC      = 4;
  localparam int RFAB_HDR_W     = 16;
  localparam int RFAB_PAY_W     = 32;
  localparam int RFAB_ERR_CNT_W = 16;

  typedef struct packed {
    logic [RFAB_HDR_W-1:0] hdr1;
    logic [RFAB_HDR_W-1:0] hdr2;
    logic [RFAB_PAY_W-1:0] payload1;
    logic [RFAB_PAY_W-1:0] payload2;
  } rfab_redund_packet_t;

  typedef rfab_redund_packet_t     [RFAB_NSLC-1:0] rfab_redund_packet_cls_t;
  typedef rfab_redund_packet_cls_t [RFAB_NCLS-1:0] rfab_redund_packet_blk_t;

  typedef struct packed {
    logic faulty_hdr;
    logic faulty_payload;
  } rfab_redund_sel_t;

  typedef enum logic [1:0] {
    OK      = 2'd0,
    SUSPECT = 2'd1,
    FAILED  = 2'd2
  } rfab_mon_state_e;

endpackage

// File: rtl/fabric_redund_lane_fsm.sv
// Leaky-threshold monitor for one field (hdr or payload).
// Macro FABRIC_REDUND_MON_CNT_EN builds the saturating event counter;
// without it err_cnt is tied to zero.
//
// state   | meaning
// OK      | no recent mismatches, copy 1 selected
// SUSPECT | mismatches seen, counting toward THRESH inside the window
// FAILED  | threshold hit, copy 2 selected until rst/clr
module fabric_redund_lane_fsm
  import fabric_pkg::*;
#(
  parameter int THRESH = 4,
  parameter int WIN    = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      evt,
  output logic                      failed,
  output logic                      irq,
  output logic [RFAB_ERR_CNT_W-1:0] err_cnt
);

  localparam logic [3:0]  THRESH_C = 4'(THRESH);
  localparam logic [15:0] WIN_LAST = 16'(WIN - 1);

  rfab_mon_state_e state_q, state_d;
  logic [3:0]      ecnt_q, ecnt_d;
  logic [15:0]     wcnt_q, wcnt_d;
  logic            irq_q, irq_d;

  // State register; rst and clr both return to OK
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= OK;
      ecnt_q  <= '0;
      wcnt_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ecnt_q  <= ecnt_d;
      wcnt_q  <= wcnt_d;
      irq_q   <= irq_d;
    end
  end

  // Next-state: events climb toward THRESH, WIN clean cycles leak back to OK
  always_comb begin
    state_d = state_q;
    ecnt_d  = ecnt_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      OK: begin
        if (evt) begin
          if (THRESH == 1) begin
            state_d = FAILED;
          end else begin
            state_d = SUSPECT;
            ecnt_d  = 4'd1;
            wcnt_d  = '0;
          end
        end
      end
      SUSPECT: begin
        if (evt) begin
          ecnt_d = ecnt_q + 4'd1;
          wcnt_d = '0;
          if (ecnt_q + 4'd1 == THRESH_C) state_d = FAILED;
        end else if (wcnt_q == WIN_LAST) begin
          state_d = OK;
          ecnt_d  = '0;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      default: begin
        state_d = FAILED;
      end
    endcase
  end

  // Outputs: select follows FAILED, irq marks the entry edge
  always_comb begin
    failed = (state_q == FAILED);
    irq_d  = (state_d == FAILED) && (state_q != FAILED);
    irq    = irq_q;
  end

`ifdef FABRIC_REDUND_MON_CNT_EN
  logic [RFAB_ERR_CNT_W-1:0] cnt_q, cnt_d;

  // Saturating event counter, counts even while FAILED
  always_comb begin
    cnt_d = cnt_q;
    if (evt && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst || clr) cnt_q <= '0;
    else            cnt_q <= cnt_d;
  end

  assign err_cnt = cnt_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: rtl/fabric_redund_monitor.sv
// Redundant fabric fault monitor: compares copy 1 vs copy 2 per valid slice,
// registers one mismatch flag per field, and feeds the per-field FSMs.
// Optional counters via FABRIC_REDUND_MON_CNT_EN.
module fabric_redund_monitor
  import fabric_pkg::*;
#(
  parameter int NCLS   = RFAB_NCLS,
  parameter int NSLC   = RFAB_NSLC,
  parameter int THRESH = 4,
  parameter int WIN    = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NCLS*NSLC-1:0]       vld_in,
  input  rfab_redund_packet_blk_t    pkt_redund,
  input  logic                       clr_fault,
  output rfab_redund_sel_t           rsel,
  output logic [RFAB_ERR_CNT_W-1:0]  hdr_err_cnt,
  output logic [RFAB_ERR_CNT_W-1:0]  pay_err_cnt,
  output logic                       fault_irq
);

  logic [NCLS*NSLC-1:0] slc_hdr_mis;
  logic [NCLS*NSLC-1:0] slc_pay_mis;
  logic hdr_mis_q, hdr_mis_d;
  logic pay_mis_q, pay_mis_d;
  logic hdr_failed, pay_failed;
  logic hdr_irq, pay_irq;

  for (genvar g = 0; g < NCLS*NSLC; g++) begin : g_slc
    assign slc_hdr_mis[g] = vld_in[g] &&
      (pkt_redund[g/NSLC][g%NSLC].hdr1 != pkt_redund[g/NSLC][g%NSLC].hdr2);
    assign slc_pay_mis[g] = vld_in[g] &&
      (pkt_redund[g/NSLC][g%NSLC].payload1 != pkt_redund[g/NSLC][g%NSLC].payload2);
  end

  // Reduce per-slice compares to one event per field
  always_comb begin
    hdr_mis_d = |slc_hdr_mis;
    pay_mis_d = |slc_pay_mis;
  end

  // Compare stage register; a clear discards the event in flight
  always_ff @(posedge clk) begin
    if (rst || clr_fault) begin
      hdr_mis_q <= 1'b0;
      pay_mis_q <= 1'b0;
    end else begin
      hdr_mis_q <= hdr_mis_d;
      pay_mis_q <= pay_mis_d;
    end
  end

  fabric_redund_lane_fsm #(.THRESH(THRESH), .WIN(WIN)) u_hdr_fsm (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_fault),
    .evt     (hdr_mis_q),
    .failed  (hdr_failed),
    .irq     (hdr_irq),
    .err_cnt (hdr_err_cnt)
  );

  fabric_redund_lane_fsm #(.THRESH(THRESH), .WIN(WIN)) u_pay_fsm (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_fault),
    .evt     (pay_mis_q),
    .failed  (pay_failed),
    .irq     (pay_irq),
    .err_cnt (pay_err_cnt)
  );

  // Select bundle and merged irq; both fields failing together is one pulse
  always_comb begin
    rsel.faulty_hdr     = hdr_failed;
    rsel.faulty_payload = pay_failed;
    fault_irq           = hdr_irq | pay_irq;
  end

endmodule

// File: tb/tb_fabric_redund_monitor.sv
module tb_fabric_redund_monitor;
  import fabric_pkg::*;

  localparam int WIN = 256;
`ifdef FABRIC_REDUND_MON_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic                    clk;
  logic                    rst;
  logic [15:0]             vld_in;
  rfab_redund_packet_blk_t pkt_redund;
  logic                    clr_fault;
  rfab_redund_sel_t        rsel;
  logic [15:0]             hdr_err_cnt;
  logic [15:0]             pay_err_cnt;
  logic                    fault_irq;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int irq_seen = 0;

  fabric_redund_monitor #(.THRESH(4), .WIN(WIN)) dut (
    .clk         (clk),
    .rst         (rst),
    .vld_in      (vld_in),
    .pkt_redund  (pkt_redund),
    .clr_fault   (clr_fault),
    .rsel        (rsel),
    .hdr_err_cnt (hdr_err_cnt),
    .pay_err_cnt (pay_err_cnt),
    .fault_irq   (fault_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] vld;
    logic [15:0] hm;
    logic [15:0] pm;
    logic        clr;
    logic        fh;
    logic        fp;
    logic        irq;
    int          hc;
    int          pc;
  } vec_t;

  vec_t vecs[19];

  function automatic logic [15:0] ec(input int n);
    return CNT_EN ? 16'(n) : 16'h0;
  endfunction

  task automatic apply(input logic [15:0] v, input logic [15:0] hm,
                       input logic [15:0] pm, input logic c, input logic r);
    logic [1:0] ci, si;
    logic [3:0] ix;
    vld_in    = v;
    clr_fault = c;
    rst       = r;
    for (int i = 0; i < 16; i++) begin
      ci = 2'(i / 4);
      si = 2'(i % 4);
      ix = 4'(i);
      pkt_redund[ci][si].hdr1     = 16'hA000 + 16'(i);
      pkt_redund[ci][si].hdr2     = (16'hA000 + 16'(i)) ^ {15'd0, hm[ix]};
      pkt_redund[ci][si].payload1 = 32'h5A5A_0000 + 32'(i);
      pkt_redund[ci][si].payload2 = (32'h5A5A_0000 + 32'(i)) ^ {pm[ix], 31'd0};
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (fault_irq) irq_seen++;
  endtask

  task automatic run(input logic [15:0] hm, input logic [15:0] pm, input int n);
    apply(16'hFFFF, hm, pm, 1'b0, 1'b0);
    repeat (n) step();
  endtask

  task automatic do_clr();
    apply(16'hFFFF, 16'h0, 16'h0, 1'b1, 1'b0);
    step();
    apply(16'hFFFF, 16'h0, 16'h0, 1'b0, 1'b0);
    irq_seen = 0;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic vec_t mk(input logic [15:0] v, input logic [15:0] hm,
                              input logic [15:0] pm, input logic c, input logic fh,
                              input logic fp, input logic irq, input int hc, input int pc);
    vec_t r;
    r.vld = v; r.hm = hm; r.pm = pm; r.clr = c;
    r.fh = fh; r.fp = fp; r.irq = irq; r.hc = hc; r.pc = pc;
    return r;
  endfunction

  initial begin
    // expected outputs are those seen after the edge that samples the row
    vecs[0]  = mk(16'hFFFF, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(16'hFFFF, 16'h0000, 16'h0200, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(16'hFFFF, 16'h0000, 16'h0200, 0, 0, 0, 0, 0, 1);
    vecs[3]  = mk(16'hFFFF, 16'h0000, 16'h0200, 0, 0, 0, 0, 0, 2);
    vecs[4]  = mk(16'hFFFF, 16'h0000, 16'h0200, 0, 0, 0, 0, 0, 3);
    vecs[5]  = mk(16'hFFFF, 16'h0000, 16'h0000, 0, 0, 1, 1, 0, 4);
    vecs[6]  = mk(16'hFFFF, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 4);
    vecs[7]  = mk(16'hFFF7, 16'h0008, 16'h0000, 0, 0, 1, 0, 0, 4);
    vecs[8]  = mk(16'hFFFF, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 4);
    vecs[9]  = mk(16'hFFFF, 16'h0000, 16'h0200, 0, 0, 1, 0, 0, 4);
    vecs[10] = mk(16'hFFFF, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 5);
    vecs[11] = mk(16'hFFFF, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 0);
    vecs[12] = mk(16'hFFFF, 16'h8001, 16'h0000, 0, 0, 0, 0, 0, 0);
    vecs[13] = mk(16'hFFFF, 16'h0000, 16'h0000, 0, 0, 0, 0, 1, 0);
    vecs[14] = mk(16'hFFFF, 16'h0001, 16'h0001, 0, 0, 0, 0, 1, 0);
    vecs[15] = mk(16'hFFFF, 16'h0000, 16'h0000, 0, 0, 0, 0, 2, 1);
    vecs[16] = mk(16'h0000, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 2, 1);
    vecs[17] = mk(16'hFFFF, 16'h0000, 16'h0000, 0, 0, 0, 0, 2, 1);
    vecs[18] = mk(16'hFFFF, 16'h0000, 16'h0000, 0, 0, 0, 0, 2, 1);

    apply(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    step(); step();
    check("rst_rsel", 32'(rsel), 32'h0);
    check("rst_irq", 32'(fault_irq), 32'h0);
    check("rst_hcnt", 32'(hdr_err_cnt), 32'h0);
    check("rst_pcnt", 32'(pay_err_cnt), 32'h0);

    // table vectors
    for (int i = 0; i < 19; i++) begin
      apply(vecs[i].vld, vecs[i].hm, vecs[i].pm, vecs[i].clr, 1'b0);
      step();
      check($sformatf("vec%0d_fh", i), 32'(rsel.faulty_hdr), 32'(vecs[i].fh));
      check($sformatf("vec%0d_fp", i), 32'(rsel.faulty_payload), 32'(vecs[i].fp));
      check($sformatf("vec%0d_irq", i), 32'(fault_irq), 32'(vecs[i].irq));
      check($sformatf("vec%0d_hc", i), 32'(hdr_err_cnt), 32'(ec(vecs[i].hc)));
      check($sformatf("vec%0d_pc", i), 32'(pay_err_cnt), 32'(ec(vecs[i].pc)));
    end

    // clean traffic
    do_clr();
    for (int i = 0; i < 1000; i++) begin
      step();
      check("clean", {rsel, fault_irq, hdr_err_cnt, pay_err_cnt}, 32'h0);
    end

    // leak back to OK after WIN clean cycles
    do_clr();
    run(16'h0010, 16'h0, 3);
    run(16'h0, 16'h0, WIN);
    run(16'h0010, 16'h0, 3);
    run(16'h0, 16'h0, 2);
    check("win_fh", 32'(rsel.faulty_hdr), 32'h0);
    check("win_hc", 32'(hdr_err_cnt), 32'(ec(6)));
    check("win_irq", 32'(irq_seen), 32'h0);

    // one clean cycle short of the window: still SUSPECT
    do_clr();
    run(16'h0010, 16'h0, 3);
    run(16'h0, 16'h0, WIN - 1);
    run(16'h0010, 16'h0, 1);
    run(16'h0, 16'h0, 2);
    check("win1_fh", 32'(rsel.faulty_hdr), 32'h1);
    check("win1_hc", 32'(hdr_err_cnt), 32'(ec(4)));
    check("win1_irq", 32'(irq_seen), 32'h1);

    // both fields fail together: one pulse
    do_clr();
    run(16'h0100, 16'h0100, 4);
    run(16'h0, 16'h0, 1);
    check("both_irq_hi", 32'(fault_irq), 32'h1);
    check("both_rsel", 32'(rsel), 32'h3);
    step();
    check("both_irq_lo", 32'(fault_irq), 32'h0);
    check("both_irq_n", 32'(irq_seen), 32'h1);

    // clear together with a mismatch
    do_clr();
    run(16'h0002, 16'h0, 4);
    run(16'h0, 16'h0, 2);
    check("clr_pre_fh", 32'(rsel.faulty_hdr), 32'h1);
    run(16'h0002, 16'h0, 1);
    apply(16'hFFFF, 16'h0002, 16'h0, 1'b1, 1'b0);
    step();
    check("clr_rsel", 32'(rsel), 32'h0);
    check("clr_hc", 32'(hdr_err_cnt), 32'h0);
    run(16'h0, 16'h0, 1);
    check("clr_post_rsel", 32'(rsel), 32'h0);
    check("clr_post_hc", 32'(hdr_err_cnt), 32'h0);
    irq_seen = 0;
    run(16'h0002, 16'h0, 1);
    run(16'h0, 16'h0, 2);
    check("clr_iso_fh", 32'(rsel.faulty_hdr), 32'h0);
    check("clr_iso_hc", 32'(hdr_err_cnt), 32'(ec(1)));
    run(16'h0002, 16'h0, 3);
    run(16'h0, 16'h0, 2);
    check("clr_susp_fh", 32'(rsel.faulty_hdr), 32'h1);
    check("clr_susp_irq", 32'(irq_seen), 32'h1);

    // reset mid-window
    do_clr();
    run(16'h0040, 16'h0, 2);
    apply(16'hFFFF, 16'h0040, 16'h0, 1'b0, 1'b1);
    step();
    apply(16'hFFFF, 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    check("rstm_hc", 32'(hdr_err_cnt), 32'h0);
    run(16'h0040, 16'h0, 3);
    run(16'h0, 16'h0, 2);
    check("rstm_fh", 32'(rsel.faulty_hdr), 32'h0);
    check("rstm_hc2", 32'(hdr_err_cnt), 32'(ec(3)));

    // counter saturation
    do_clr();
    apply(16'hFFFF, 16'h0, 16'hFFFF, 1'b0, 1'b0);
    for (int i = 1; i <= 70000; i++) begin
      step();
      if (i == 1000)  check("sat_1000", 32'(pay_err_cnt), 32'(ec(999)));
      if (i == 65535) check("sat_fffe", 32'(pay_err_cnt), 32'(ec(65534)));
      if (i == 65536) check("sat_ffff", 32'(pay_err_cnt), 32'(ec(65535)));
    end
    run(16'h0, 16'h0, 2);
    check("sat_end", 32'(pay_err_cnt), 32'(ec(65535)));
    check("sat_fp", 32'(rsel.faulty_payload), 32'h1);
    check("sat_hc", 32'(hdr_err_cnt), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/fabric_redund_monitor.md
# fabric_redund_monitor

Fault monitor for the redundant request fabric. It compares the duplicated header and payload copies (copy 1 against copy 2) on every valid slice of the fabric output and runs one leaky-threshold state machine per field. It drives the `rsel` failover selects consumed by the compress stage. Copy 1 is primary: a persistent mismatch moves that field's select to copy 2 until software clears it.

## Interface
Parameters:
- `NCLS`, 4, number of classes
- `NSLC`, 4, number of slices per class
- `THRESH`, 4, mismatch events inside one window that declare a field FAILED (range 1..15)
- `WIN`, 256, consecutive clean cycles that return SUSPECT to OK (range 2..65536)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  fabric clock
- `rst`  in  1  synchronous active-high reset
- `vld_in`  in  NCLS*NSLC  per-slice valid, bit index = cls*NSLC+slc
- `pkt_redund`  in  `rfab_redund_packet_blk_t`  dual-copy fabric output (hdr1/hdr2/payload1/payload2 per slice)
- `clr_fault`  in  1  software clear of both FSMs and counters
- `rsel`  out  `rfab_redund_sel_t`  `faulty_hdr` / `faulty_payload`, registered
- `hdr_err_cnt`  out  16  saturating count of header mismatch events
- `pay_err_cnt`  out  16  saturating count of payload mismatch events
- `fault_irq`  out  1  single-cycle pulse on any field entering FAILED

## Operation
- Mismatch event: in a given cycle, at least one slice has its `vld_in` bit set and copy 1 differs from copy 2 for that field. Slices whose `vld_in` bit is clear are ignored. Each cycle produces at most one event per field.
- Each field (hdr, payload) has its own FSM with states OK, SUSPECT and FAILED, plus a 4-bit event counter `ecnt` and a window counter `wcnt`.
- OK transitions:
  - Event with THRESH==1 → FAILED.
  - Event with THRESH>1 → SUSPECT, `ecnt`=1, `wcnt`=0.
- SUSPECT transitions:
  - Event: `ecnt`+1 and `wcnt`=0. If the new `ecnt`==THRESH → FAILED.
  - No event: `wcnt`+1. When `wcnt` reaches WIN-1 → OK, `ecnt`=0.
- FAILED is sticky and ignores events for the FSM. It exits only through `rst` or `clr_fault`, both of which return the FSM to OK.
- `rsel.faulty_x` = 1 exactly while field x is in FAILED.
- `fault_irq` pulses 1 for one cycle on the OK/SUSPECT→FAILED transition. If both fields fail in the same cycle, it is still one pulse.
- Error counters:
  - They increment on every event, including events seen while in FAILED.
  - They saturate at 0xFFFF.
  - `clr_fault` zeroes them.
- Simultaneous `clr_fault` and event: the clear wins. The event in the compare stage is discarded, so counters and FSMs read zero/OK on the next cycle.
- Reset values: `rsel`=0, both counters 0, `fault_irq`=0, both FSMs OK, compare stage cleared.

## Timing
- Stage 1 (edge N+1): per-slice compare of inputs sampled at edge N, reduced per field and registered as `hdr_mis` / `pay_mis`.
- Stage 2 (edge N+2): FSM, counters, `rsel` and `fault_irq` update.
- Latency from a mismatching input cycle N to a change on `rsel` is 2 clocks. `fault_irq` is high during cycle N+2.
- Both `rst` and `clr_fault` take effect at the next edge and also clear stage 1.
- Mid-window reset behaves identically to `clr_fault`.

## Configuration
- `FABRIC_REDUND_MON_CNT_EN` defined: the 16-bit saturating counters are built, and `hdr_err_cnt` / `pay_err_cnt` report them.
- Undefined: the counter registers are not built and both outputs are tied to 0. FSM, `rsel` and `fault_irq` behaviour is unchanged.

## Structure
- The following go in `fabric_pkg`:
  - `rfab_redund_packet_t` and its `_cls_t` / `_blk_t` typedefs, moved out of the block-level fabric so producer and monitor share them.
  - Enum `rfab_mon_state_e` {OK, SUSPECT, FAILED}.
  - Constant `RFAB_ERR_CNT_W`=16.
- Sub-module `fabric_redund_lane_fsm`: one field's FSM, `ecnt`, `wcnt`, saturating counter and irq edge. It is instantiated twice (hdr, payload). The top level holds only the compare/reduce stage and the output OR for `fault_irq`.

## Test plan
- Clean traffic, all 16 `vld_in` set, copies equal, 1000 cycles → `rsel`=0, counters 0, no `fault_irq`.
- Payload mismatch on slice [2][1] for 4 consecutive valid cycles starting at cycle 10 (THRESH=4) → `faulty_payload`=1 and `fault_irq` pulse at cycle 15 (event cycles 10–13; `ecnt` reaches THRESH on the event from cycle 13, 2-clock latency), `pay_err_cnt`=4, `faulty_hdr` stays 0.
- Three hdr mismatches, then WIN clean cycles, then 3 more → FSM returns to OK, never reaches FAILED, `hdr_err_cnt`=6.
- Mismatch on a slice whose `vld_in` bit is 0 → no event, counters unchanged.
- Header FAILED, then `clr_fault` asserted in the same cycle as a new mismatch → next cycle `rsel`=0 and `hdr_err_cnt`=0; a following isolated mismatch enters SUSPECT only.
- Force 70000 payload events with `FABRIC_REDUND_MON_CNT_EN` defined → `pay_err_cnt` holds 0xFFFF. With the macro undefined → the output reads 0 throughout.
